// File: rtl/reorder_buffer_pkg.sv
// rtl/reorder_buffer_pkg.sv - shared ROB types, tag encoding and instruction classes
package reorder_buffer_pkg;

    localparam int ROB_DEPTH     = 16;
    localparam int ROB_TAG_W     = 6;
    localparam int ROB_DATA_W    = 32;
    localparam int NUM_ARCH_REGS = 32;
    localparam int ARCH_REG_W    = $clog2(NUM_ARCH_REGS);

    localparam logic [ROB_TAG_W-1:0] ROB_INVALID_TAG = 6'b010000;

    // Instruction class encoding shared with the register status table and reservation stations.
    typedef enum logic [2:0] {
        INSN_ALU    = 3'd0,
        INSN_MUL    = 3'd1,
        INSN_LOAD   = 3'd2,
        INSN_STORE  = 3'd3,
        INSN_BRANCH = 3'd4,
        INSN_JUMP   = 3'd5,
        INSN_FP     = 3'd6,
        INSN_SYS    = 3'd7
    } insn_class_e;

    typedef struct packed {
        logic                  valid;
        logic                  done;
        logic [ARCH_REG_W-1:0] dest;
        insn_class_e           insn_type;
        logic [ROB_DATA_W-1:0] value;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_forward_mux.sv
// rtl/reorder_buffer_forward_mux.sv - one operand lookup with same-cycle CDB bypass
module rob_forward_mux #(
    parameter int DEPTH  = 16,
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32
) (
    input  logic [TAG_W-1:0]  i_q_tag,
    input  logic              i_cdb_valid,
    input  logic [TAG_W-1:0]  i_cdb_tag,
    input  logic [DATA_W-1:0] i_cdb_value,
    input  logic              i_entry_valid,
    input  logic              i_entry_done,
    input  logic [DATA_W-1:0] i_entry_value,
    output logic              o_q_ready,
    output logic [DATA_W-1:0] o_q_value
);

    logic w_in_range;
    logic w_bypass;

    assign w_in_range = (i_q_tag < TAG_W'(DEPTH));
    assign w_bypass   = i_cdb_valid && (i_cdb_tag == i_q_tag);

    // The CDB wins over the stored copy so a consumer never misses a result broadcast this cycle.
    always_comb begin
        o_q_ready = 1'b0;
        o_q_value = '0;
        if (w_in_range) begin
            if (w_bypass) begin
                o_q_ready = 1'b1;
                o_q_value = i_cdb_value;
            end else begin
                o_q_ready = i_entry_valid && i_entry_done;
                o_q_value = i_entry_value;
            end
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order retirement buffer: tag allocation, CDB capture, forwarding, commit
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int                DEPTH       = ROB_DEPTH,
    parameter int                TAG_W       = ROB_TAG_W,
    parameter int                DATA_W      = ROB_DATA_W,
    parameter logic [TAG_W-1:0]  INVALID_TAG = ROB_INVALID_TAG
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              alloc_valid,
    input  logic [4:0]        alloc_dest,
    input  logic [2:0]        alloc_type,
    output logic              alloc_ready,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_value,
    input  logic [TAG_W-1:0]  q_tag1,
    input  logic [TAG_W-1:0]  q_tag2,
    output logic              q_ready1,
    output logic              q_ready2,
    output logic [DATA_W-1:0] q_value1,
    output logic [DATA_W-1:0] q_value2,
    output logic              commit_valid,
    input  logic              commit_ready,
    output logic [4:0]        commit_dest,
    output logic [2:0]        commit_type,
    output logic [TAG_W-1:0]  commit_tag,
    output logic [DATA_W-1:0] commit_value,
    output logic [4:0]        count
);

    localparam int PTR_W = $clog2(DEPTH);

    // The no-producer tag must never alias a real entry.
    if (INVALID_TAG < TAG_W'(DEPTH)) begin : g_bad_invalid_tag
        $error("INVALID_TAG collides with an entry index");
    end

    rob_entry_t       r_rob [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [4:0]       r_count;

    logic             w_do_alloc;
    logic             w_do_commit;
    logic             w_cdb_hit;
    logic [PTR_W-1:0] w_cdb_idx;
    rob_entry_t       w_head_entry;
    rob_entry_t       w_q_entry1;
    rob_entry_t       w_q_entry2;

    assign w_head_entry = r_rob[r_head];
    assign w_cdb_idx    = cdb_tag[PTR_W-1:0];
    assign w_q_entry1   = r_rob[q_tag1[PTR_W-1:0]];
    assign w_q_entry2   = r_rob[q_tag2[PTR_W-1:0]];

    assign alloc_ready  = (r_count != 5'(DEPTH));
    assign alloc_tag    = TAG_W'(r_tail);
    assign count        = r_count;

    assign commit_valid = w_head_entry.valid && w_head_entry.done;
    assign commit_dest  = w_head_entry.dest;
    assign commit_type  = w_head_entry.insn_type;
    assign commit_tag   = TAG_W'(r_head);
    assign commit_value = w_head_entry.value;

    assign w_do_alloc   = alloc_valid && alloc_ready;
    assign w_do_commit  = commit_valid && commit_ready;
    assign w_cdb_hit    = cdb_valid && (cdb_tag < TAG_W'(DEPTH)) && r_rob[w_cdb_idx].valid;

    // Allocation targets an invalid tail slot and the CDB only hits valid slots, so their writes never overlap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_rob[i] <= '0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_rob[i].valid <= 1'b0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_alloc) begin
                r_rob[r_tail].valid     <= 1'b1;
                r_rob[r_tail].done      <= 1'b0;
                r_rob[r_tail].dest      <= alloc_dest;
                r_rob[r_tail].insn_type <= insn_class_e'(alloc_type);
                r_tail                  <= r_tail + PTR_W'(1);
            end
            if (w_cdb_hit) begin
                r_rob[w_cdb_idx].value <= cdb_value;
                r_rob[w_cdb_idx].done  <= 1'b1;
            end
            if (w_do_commit) begin
                r_rob[r_head].valid <= 1'b0;
                r_head              <= r_head + PTR_W'(1);
            end
            if (w_do_alloc && !w_do_commit) begin
                r_count <= r_count + 5'd1;
            end else if (!w_do_alloc && w_do_commit) begin
                r_count <= r_count - 5'd1;
            end
        end
    end

    rob_forward_mux #(
        .DEPTH  (DEPTH),
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W)
    ) u_fwd1 (
        .i_q_tag       (q_tag1),
        .i_cdb_valid   (cdb_valid),
        .i_cdb_tag     (cdb_tag),
        .i_cdb_value   (cdb_value),
        .i_entry_valid (w_q_entry1.valid),
        .i_entry_done  (w_q_entry1.done),
        .i_entry_value (w_q_entry1.value),
        .o_q_ready     (q_ready1),
        .o_q_value     (q_value1)
    );

    rob_forward_mux #(
        .DEPTH  (DEPTH),
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W)
    ) u_fwd2 (
        .i_q_tag       (q_tag2),
        .i_cdb_valid   (cdb_valid),
        .i_cdb_tag     (cdb_tag),
        .i_cdb_value   (cdb_value),
        .i_entry_valid (w_q_entry2.valid),
        .i_entry_done  (w_q_entry2.done),
        .i_entry_value (w_q_entry2.value),
        .o_q_ready     (q_ready2),
        .o_q_value     (q_value2)
    );

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - scoreboard bench for reorder_buffer
module tb_reorder_buffer;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        alloc_valid;
    logic [4:0]  alloc_dest;
    logic [2:0]  alloc_type;
    logic        alloc_ready;
    logic [5:0]  alloc_tag;
    logic        cdb_valid;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic [5:0]  q_tag1;
    logic [5:0]  q_tag2;
    logic        q_ready1;
    logic        q_ready2;
    logic [31:0] q_value1;
    logic [31:0] q_value2;
    logic        commit_valid;
    logic        commit_ready;
    logic [4:0]  commit_dest;
    logic [2:0]  commit_type;
    logic [5:0]  commit_tag;
    logic [31:0] commit_value;
    logic [4:0]  count;

    typedef struct {
        logic [5:0] tag;
        logic [4:0] dest;
        logic [2:0] ty;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_val [16];
    int          checks = 0;
    int          errors = 0;
    int          n_commits = 0;

    reorder_buffer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .alloc_valid  (alloc_valid),
        .alloc_dest   (alloc_dest),
        .alloc_type   (alloc_type),
        .alloc_ready  (alloc_ready),
        .alloc_tag    (alloc_tag),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .cdb_value    (cdb_value),
        .q_tag1       (q_tag1),
        .q_tag2       (q_tag2),
        .q_ready1     (q_ready1),
        .q_ready2     (q_ready2),
        .q_value1     (q_value1),
        .q_value2     (q_value2),
        .commit_valid (commit_valid),
        .commit_ready (commit_ready),
        .commit_dest  (commit_dest),
        .commit_type  (commit_type),
        .commit_tag   (commit_tag),
        .commit_value (commit_value),
        .count        (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_alloc(input logic [5:0] tag, input logic [4:0] dest, input logic [2:0] ty);
        exp_t e;
        e.tag  = tag;
        e.dest = dest;
        e.ty   = ty;
        exp_q.push_back(e);
    endtask

    // Monitor: every accepted commit must match the oldest outstanding allocation.
    always @(negedge clk) begin
        if (rst_n && commit_valid && commit_ready) begin
            n_commits++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL commit_unexpected actual_tag=%0d expected=none", commit_tag);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("commit_tag", 32'(commit_tag), 32'(e.tag));
                chk("commit_dest", 32'(commit_dest), 32'(e.dest));
                chk("commit_type", 32'(commit_type), 32'(e.ty));
                chk("commit_value", commit_value, model_val[e.tag[3:0]]);
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0;
        alloc_valid = 1'b0; alloc_dest = '0; alloc_type = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0;
        q_tag1 = '0; q_tag2 = '0; commit_ready = 1'b0;
        for (int i = 0; i < 16; i++) model_val[i] = '0;

        @(negedge clk);
        chk("rst_alloc_ready", 32'(alloc_ready), 32'd1);
        chk("rst_alloc_tag", 32'(alloc_tag), 32'd0);
        chk("rst_commit_valid", 32'(commit_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_q_ready1", 32'(q_ready1), 32'd0);
        chk("rst_q_value1", q_value1, 32'd0);
        step();
        rst_n = 1'b1;

        // Three allocations: tags 0, 1, 2.
        alloc_valid = 1'b1;
        alloc_dest = 5'd5; alloc_type = 3'd1;
        @(negedge clk); chk("alloc_tag0", 32'(alloc_tag), 32'd0); push_alloc(6'd0, 5'd5, 3'd1);
        step();
        alloc_dest = 5'd7; alloc_type = 3'd2;
        @(negedge clk); chk("alloc_tag1", 32'(alloc_tag), 32'd1); push_alloc(6'd1, 5'd7, 3'd2);
        step();
        alloc_dest = 5'd9; alloc_type = 3'd3;
        @(negedge clk); chk("alloc_tag2", 32'(alloc_tag), 32'd2); push_alloc(6'd2, 5'd9, 3'd3);
        step();
        alloc_valid = 1'b0;
        @(negedge clk);
        chk("count3", 32'(count), 32'd3);
        chk("commit_valid_idle", 32'(commit_valid), 32'd0);

        // Out-of-order completion, in-order commit.
        step();
        cdb_valid = 1'b1; cdb_tag = 6'd1; cdb_value = 32'hAA; model_val[1] = 32'hAA;
        step();
        cdb_tag = 6'd0; cdb_value = 32'h55; model_val[0] = 32'h55;
        @(negedge clk); chk("no_cdb_commit_bypass", 32'(commit_valid), 32'd0);
        step();
        cdb_valid = 1'b0;
        commit_ready = 1'b1;
        @(negedge clk); chk("commit_valid_after_cdb", 32'(commit_valid), 32'd1);
        step();
        step();
        @(negedge clk);
        chk("commit_valid_head2", 32'(commit_valid), 32'd0);
        chk("count_after_commits", 32'(count), 32'd1);
        chk("head_is_2", 32'(commit_tag), 32'd2);
        step();
        commit_ready = 1'b0;

        // Fill to 16 with wrap: tags 3..15, 0, 1.
        alloc_valid = 1'b1;
        for (int i = 0; i < 15; i++) begin
            alloc_dest = 5'(i); alloc_type = 3'(i);
            @(negedge clk);
            chk("fill_alloc_tag", 32'(alloc_tag), 32'((3 + i) % 16));
            push_alloc(6'((3 + i) % 16), 5'(i), 3'(i));
            step();
        end
        alloc_valid = 1'b0;
        @(negedge clk);
        chk("full_count", 32'(count), 32'd16);
        chk("full_alloc_ready", 32'(alloc_ready), 32'd0);
        step();
        cdb_valid = 1'b1; cdb_tag = 6'd2; cdb_value = 32'h99; model_val[2] = 32'h99;
        step();
        cdb_valid = 1'b0;
        commit_ready = 1'b1; alloc_valid = 1'b1; alloc_dest = 5'd30; alloc_type = 3'd6;
        @(negedge clk); chk("full_alloc_blocked_on_commit", 32'(alloc_ready), 32'd0);
        step();
        alloc_valid = 1'b0;
        @(negedge clk);
        chk("count_after_full_commit", 32'(count), 32'd15);
        chk("alloc_ready_reopen", 32'(alloc_ready), 32'd1);
        chk("alloc_tag_old_head", 32'(alloc_tag), 32'd2);
        step();

        flush = 1'b1;
        step();
        flush = 1'b0;
        exp_q.delete();
        @(negedge clk); chk("flush1_count", 32'(count), 32'd0);
        step();

        // Forwarding, then flush with 4 live entries and concurrent alloc/CDB.
        alloc_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            alloc_dest = 5'(10 + i); alloc_type = 3'd0;
            push_alloc(6'(i), 5'(10 + i), 3'd0);
            step();
        end
        alloc_valid = 1'b0;
        cdb_valid = 1'b1; cdb_tag = 6'd3; cdb_value = 32'h1234; model_val[3] = 32'h1234;
        q_tag1 = 6'd3; q_tag2 = 6'd16;
        @(negedge clk);
        chk("fwd_bypass_ready1", 32'(q_ready1), 32'd1);
        chk("fwd_bypass_value1", q_value1, 32'h1234);
        chk("fwd_invalid_ready2", 32'(q_ready2), 32'd0);
        chk("fwd_invalid_value2", q_value2, 32'd0);
        step();
        cdb_valid = 1'b0; q_tag2 = 6'd1;
        @(negedge clk);
        chk("fwd_stored_ready1", 32'(q_ready1), 32'd1);
        chk("fwd_stored_value1", q_value1, 32'h1234);
        chk("fwd_not_done_ready2", 32'(q_ready2), 32'd0);
        step();
        flush = 1'b1; alloc_valid = 1'b1; alloc_dest = 5'd20;
        cdb_valid = 1'b1; cdb_tag = 6'd2; cdb_value = 32'hDEAD;
        step();
        flush = 1'b0; alloc_valid = 1'b0; cdb_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_tail", 32'(alloc_tag), 32'd0);
        chk("flush_head", 32'(commit_tag), 32'd0);
        chk("flush_commit_valid", 32'(commit_valid), 32'd0);
        chk("flush_q_ready1", 32'(q_ready1), 32'd0);
        step();
        cdb_valid = 1'b1; cdb_tag = 6'd2; cdb_value = 32'hBEEF;
        step();
        cdb_valid = 1'b0; q_tag1 = 6'd2;
        @(negedge clk);
        chk("cdb_to_invalid_ignored", 32'(q_ready1), 32'd0);
        chk("cdb_to_invalid_count", 32'(count), 32'd0);
        step();

        alloc_valid = 1'b1; alloc_dest = 5'd3; alloc_type = 3'd4;
        push_alloc(6'd0, 5'd3, 3'd4);
        step();
        alloc_valid = 1'b0;
        cdb_valid = 1'b1; cdb_tag = 6'd0; cdb_value = 32'h77; model_val[0] = 32'h77;
        step();
        cdb_valid = 1'b0;
        step();
        @(negedge clk); chk("post_flush_commit_count", 32'(count), 32'd0);
        step();

        // Asynchronous reset between edges with a commit pending.
        commit_ready = 1'b0;
        alloc_valid = 1'b1; alloc_dest = 5'd1; alloc_type = 3'd2;
        push_alloc(6'd1, 5'd1, 3'd2);
        step();
        alloc_dest = 5'd2; alloc_type = 3'd2;
        push_alloc(6'd2, 5'd2, 3'd2);
        cdb_valid = 1'b1; cdb_tag = 6'd1; cdb_value = 32'h5A; model_val[1] = 32'h5A;
        step();
        alloc_valid = 1'b0; cdb_valid = 1'b0;
        @(negedge clk);
        chk("pre_reset_commit_valid", 32'(commit_valid), 32'd1);
        chk("pre_reset_count", 32'(count), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_commit_valid", 32'(commit_valid), 32'd0);
        chk("async_rst_count", 32'(count), 32'd0);
        chk("async_rst_alloc_ready", 32'(alloc_ready), 32'd1);
        chk("async_rst_alloc_tag", 32'(alloc_tag), 32'd0);
        chk("async_rst_q_ready1", 32'(q_ready1), 32'd0);
        chk("async_rst_q_value1", q_value1, 32'd0);
        exp_q.delete();
        step();
        rst_n = 1'b1;
        step();
        chk("total_commits", 32'(n_commits), 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
